hif_i2c_target: RTL and testbench

//   I2C target (slave) that answers an external I2C master on the host interface.

---
 rtl/hif_i2c_target_if.sv | 12 +
 rtl/hif_i2c_target.sv | 214 +++++++++++++++++++++
 tb/tb_hif_i2c_target.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/hif_i2c_target_if.sv
// Register strobe bus between the I2C target and the on-chip register file.
// The I2C target drives address/data/strobes (master); the register file returns read data (slave).
interface hif_i2c_target_if;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata);
    modport slave  (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/hif_i2c_target.sv
// I2C target: START/STOP decode, 7-bit address match, pointer + auto-increment register access.
// Optional HIF_I2C_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA after the synchroniser.
module hif_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            xtal_clk,
    input  logic            por_rst,
    input  logic            scl_in,
    input  logic            sda_in,
    output logic            sda_oe,
    output logic            busy,
    output logic            hif_idle_out,
    hif_i2c_target_if.master regs
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK,
        RD_LOAD, RDATA, RD_MACK, WAIT_STOP
    } state_t;

    // Bit 1 = SCL, bit 0 = SDA throughout the input path; reset to the idle-bus level.
    genvar gi;
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [1:0] stage_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge xtal_clk) begin
                if (por_rst) stage_reg <= 2'b11;
                else         stage_reg <= {scl_in, sda_in};
            end
        end else begin : g_next
            always_ff @(posedge xtal_clk) begin
                if (por_rst) stage_reg <= 2'b11;
                else         stage_reg <= g_sync[gi-1].stage_reg;
            end
        end
    end

    logic [1:0] sync_out;
    logic [1:0] bus_s;
    logic [1:0] bus_d_reg;
    assign sync_out = g_sync[SYNC_STAGES-1].stage_reg;

`ifdef HIF_I2C_GLITCH_FILTER_EN
    logic [1:0] hist1_reg, hist2_reg, filt_reg;
    always_ff @(posedge xtal_clk) begin
        if (por_rst) begin
            hist1_reg <= 2'b11;
            hist2_reg <= 2'b11;
            filt_reg  <= 2'b11;
        end else begin
            hist1_reg <= sync_out;
            hist2_reg <= hist1_reg;
            filt_reg  <= (sync_out & hist1_reg) | (sync_out & hist2_reg) | (hist1_reg & hist2_reg);
        end
    end
    assign bus_s = filt_reg;
`else
    assign bus_s = sync_out;
`endif

    always_ff @(posedge xtal_clk) begin
        if (por_rst) bus_d_reg <= 2'b11;
        else         bus_d_reg <= bus_s;
    end

    logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
    assign scl_s     = bus_s[1];
    assign sda_s     = bus_s[0];
    assign scl_rise  =  bus_s[1] & ~bus_d_reg[1];
    assign scl_fall  = ~bus_s[1] &  bus_d_reg[1];
    assign sda_rise  =  bus_s[0] & ~bus_d_reg[0];
    assign sda_fall  = ~bus_s[0] &  bus_d_reg[0];
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    state_t     state_reg;
    logic [3:0] bit_cnt_reg;
    logic [7:0] shift_reg, tx_reg, reg_addr_reg, reg_wdata_reg;
    logic [1:0] ld_cnt_reg;
    logic       rw_reg, ack_drv_reg, inc_pend_reg, reg_we_reg, reg_re_reg, sda_oe_reg, busy_reg;
    logic [7:0] rx_byte;
    assign rx_byte = {shift_reg[6:0], sda_s};

    always_ff @(posedge xtal_clk) begin
        if (por_rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 4'd0;
            shift_reg     <= 8'h00;
            tx_reg        <= 8'hFF;
            reg_addr_reg  <= 8'h00;
            reg_wdata_reg <= 8'h00;
            ld_cnt_reg    <= 2'd0;
            rw_reg        <= 1'b0;
            ack_drv_reg   <= 1'b0;
            inc_pend_reg  <= 1'b0;
            reg_we_reg    <= 1'b0;
            reg_re_reg    <= 1'b0;
            sda_oe_reg    <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            reg_we_reg <= 1'b0;
            reg_re_reg <= 1'b0;
            // Post-write increment lands the cycle after the strobe so reg_we sees the old pointer.
            if (inc_pend_reg) begin
                reg_addr_reg <= reg_addr_reg + 8'd1;
                inc_pend_reg <= 1'b0;
            end
            if (start_det) begin
                state_reg   <= ADDR;
                bit_cnt_reg <= 4'd0;
                sda_oe_reg  <= 1'b0;
                ack_drv_reg <= 1'b0;
                busy_reg    <= 1'b1;
            end else if (stop_det) begin
                state_reg   <= IDLE;
                sda_oe_reg  <= 1'b0;
                ack_drv_reg <= 1'b0;
                busy_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shift_reg   <= rx_byte;
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            if (bit_cnt_reg == 4'd7) begin
                                bit_cnt_reg <= 4'd0;
                                if (state_reg == ADDR) begin
                                    rw_reg    <= sda_s;
                                    state_reg <= (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
                                end else if (state_reg == PTR) begin
                                    reg_addr_reg <= rx_byte;
                                    state_reg    <= PTR_ACK;
                                end else begin
                                    reg_wdata_reg <= rx_byte;
                                    reg_we_reg    <= 1'b1;
                                    inc_pend_reg  <= 1'b1;
                                    state_reg     <= WDATA_ACK;
                                end
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        // Read requests fetch the first byte on the ACK clock's rising edge.
                        if (scl_rise && ack_drv_reg && state_reg == ADDR_ACK && rw_reg) begin
                            reg_re_reg  <= 1'b1;
                            ld_cnt_reg  <= 2'd0;
                            ack_drv_reg <= 1'b0;
                            state_reg   <= RD_LOAD;
                        end else if (scl_fall) begin
                            if (!ack_drv_reg) begin
                                sda_oe_reg  <= 1'b1;
                                ack_drv_reg <= 1'b1;
                            end else begin
                                sda_oe_reg  <= 1'b0;
                                ack_drv_reg <= 1'b0;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= (state_reg == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                    RD_LOAD: begin
                        if (ld_cnt_reg == 2'd0) begin
                            ld_cnt_reg <= 2'd1;
                        end else if (ld_cnt_reg == 2'd1) begin
                            tx_reg       <= regs.reg_rdata;
                            reg_addr_reg <= reg_addr_reg + 8'd1;
                            ld_cnt_reg   <= 2'd2;
                        end else if (scl_fall) begin
                            sda_oe_reg  <= ~tx_reg[7];
                            tx_reg      <= {tx_reg[6:0], 1'b1};
                            bit_cnt_reg <= 4'd1;
                            state_reg   <= RDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt_reg == 4'd8) begin
                                sda_oe_reg <= 1'b0;
                                state_reg  <= RD_MACK;
                            end else begin
                                sda_oe_reg  <= ~tx_reg[7];
                                tx_reg      <= {tx_reg[6:0], 1'b1};
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    RD_MACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                reg_re_reg <= 1'b1;
                                ld_cnt_reg <= 2'd0;
                                state_reg  <= RD_LOAD;
                            end else begin
                                state_reg <= WAIT_STOP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe          = sda_oe_reg;
    assign busy            = busy_reg;
    assign hif_idle_out    = (state_reg == IDLE) && !busy_reg;
    assign regs.reg_addr   = reg_addr_reg;
    assign regs.reg_wdata  = reg_wdata_reg;
    // Strobes are masked during reset so a pulse registered just before reset never escapes.
    assign regs.reg_we     = reg_we_reg & ~por_rst;
    assign regs.reg_re     = reg_re_reg & ~por_rst;

endmodule

// File: tb/tb_hif_i2c_target.sv
// Directed bench for hif_i2c_target: bit-banged I2C master, open-drain SDA, registered-read regfile model.
module tb_hif_i2c_target;
    localparam int Q = 8;

    logic xtal_clk = 1'b0;
    logic por_rst  = 1'b1;
    logic scl_in   = 1'b1;
    logic sda_m    = 1'b1;
    logic sda_line;
    logic sda_oe, busy, hif_idle_out;

    hif_i2c_target_if regs();

    assign sda_line = sda_m & ~sda_oe;

    hif_i2c_target dut (
        .xtal_clk     (xtal_clk),
        .por_rst      (por_rst),
        .scl_in       (scl_in),
        .sda_in       (sda_line),
        .sda_oe       (sda_oe),
        .busy         (busy),
        .hif_idle_out (hif_idle_out),
        .regs         (regs)
    );

    always #5 xtal_clk = ~xtal_clk;

    // Register file model with logging of every strobe
    logic [7:0] mem [256];
    logic [7:0] rdata_q = 8'h00;
    logic [7:0] we_a [64];
    logic [7:0] we_d [64];
    int we_cnt = 0, re_cnt = 0, both_cnt = 0, busy_cnt = 0;
    assign regs.reg_rdata = rdata_q;

    always @(posedge xtal_clk) begin
        if (regs.reg_we) begin
            mem[regs.reg_addr]  <= regs.reg_wdata;
            we_a[we_cnt % 64]   <= regs.reg_addr;
            we_d[we_cnt % 64]   <= regs.reg_wdata;
            we_cnt              <= we_cnt + 1;
        end
        if (regs.reg_re) begin
            rdata_q <= mem[regs.reg_addr];
            re_cnt  <= re_cnt + 1;
        end
        if (regs.reg_we && regs.reg_re) both_cnt <= both_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge xtal_clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; tick(Q);
        scl_in = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_in = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; tick(Q);
        scl_in = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; tick(Q);
        scl_in = 1'b1; tick(2 * Q);
        scl_in = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_in = 1'b1; tick(Q);
        b = sda_line; tick(Q);
        scl_in = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(mack);
    endtask

    logic       ack;
    logic [7:0] rd;
    int we_base, re_base, busy_base;

    initial begin
        // Reset state
        tick(4);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_reg_addr", regs.reg_addr, 8'h00);
        check("rst_reg_wdata", regs.reg_wdata, 8'h00);
        check("rst_reg_we", regs.reg_we, 0);
        check("rst_reg_re", regs.reg_re, 0);
        check("rst_busy", busy, 0);
        check("rst_idle", hif_idle_out, 1);
        por_rst = 1'b0;
        tick(4);
        check("post_rst_idle", hif_idle_out, 1);

        // Write two bytes at pointer 0x10
        we_base = we_cnt; re_base = re_cnt;
        i2c_start;
        check("wr_busy", busy, 1);
        check("wr_not_idle", hif_idle_out, 0);
        write_byte(8'hA0, ack); check("wr_addr_ack", ack, 0);
        write_byte(8'h10, ack); check("wr_ptr_ack", ack, 0);
        write_byte(8'h5A, ack); check("wr_d0_ack", ack, 0);
        write_byte(8'h3C, ack); check("wr_d1_ack", ack, 0);
        i2c_stop;
        check("wr_we_count", we_cnt - we_base, 2);
        check("wr_we0_addr", we_a[we_base % 64], 8'h10);
        check("wr_we0_data", we_d[we_base % 64], 8'h5A);
        check("wr_we1_addr", we_a[(we_base + 1) % 64], 8'h11);
        check("wr_we1_data", we_d[(we_base + 1) % 64], 8'h3C);
        check("wr_reg_addr", regs.reg_addr, 8'h12);
        check("wr_no_re", re_cnt - re_base, 0);
        check("wr_busy_after_stop", busy, 0);
        check("wr_idle_after_stop", hif_idle_out, 1);

        // Preload 0x20/0x21, then read them back via pointer write + repeated START
        i2c_start;
        write_byte(8'hA0, ack); check("pre_addr_ack", ack, 0);
        write_byte(8'h20, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack); check("pre_d1_ack", ack, 0);
        i2c_stop;
        we_base = we_cnt; re_base = re_cnt;
        i2c_start;
        write_byte(8'hA0, ack); check("rd_waddr_ack", ack, 0);
        write_byte(8'h20, ack); check("rd_ptr_ack", ack, 0);
        i2c_start;
        write_byte(8'hA1, ack); check("rd_raddr_ack", ack, 0);
        read_byte(1'b0, rd); check("rd_byte0", rd, 8'h11);
        read_byte(1'b1, rd); check("rd_byte1", rd, 8'h22);
        check("rd_released", sda_oe, 0);
        check("rd_busy_wait_stop", busy, 1);
        check("rd_re_count", re_cnt - re_base, 2);
        check("rd_reg_addr", regs.reg_addr, 8'h22);
        check("rd_no_we", we_cnt - we_base, 0);
        i2c_stop;
        check("rd_idle_after_stop", hif_idle_out, 1);

        // Wrong device address
        we_base = we_cnt; re_base = re_cnt;
        i2c_start;
        write_byte(8'hA4, ack); check("bad_addr_nack", ack, 1);
        write_byte(8'h55, ack); check("bad_data_nack", ack, 1);
        check("bad_busy", busy, 1);
        check("bad_no_we", we_cnt - we_base, 0);
        check("bad_no_re", re_cnt - re_base, 0);
        i2c_stop;
        check("bad_busy_after_stop", busy, 0);

        // Pointer wrap
        we_base = we_cnt;
        i2c_start;
        write_byte(8'hA0, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h01, ack); check("wrap_d0_ack", ack, 0);
        write_byte(8'h02, ack); check("wrap_d1_ack", ack, 0);
        i2c_stop;
        check("wrap_we0_addr", we_a[we_base % 64], 8'hFF);
        check("wrap_we0_data", we_d[we_base % 64], 8'h01);
        check("wrap_we1_addr", we_a[(we_base + 1) % 64], 8'h00);
        check("wrap_we1_data", we_d[(we_base + 1) % 64], 8'h02);
        check("wrap_reg_addr", regs.reg_addr, 8'h01);

        // Reset while the target holds an address ACK
        i2c_start;
        for (int i = 7; i >= 0; i--) write_bit(((8'hA0 >> i) & 8'h01) != 8'h00);
        sda_m = 1'b1;
        tick(Q);
        check("mid_ack_driving", sda_oe, 1);
        por_rst = 1'b1;
        tick(1);
        por_rst = 1'b0;
        check("mid_rst_sda_oe", sda_oe, 0);
        check("mid_rst_idle", hif_idle_out, 1);
        tick(Q);
        i2c_stop;
        we_base = we_cnt;
        i2c_start;
        write_byte(8'hA0, ack); check("post_rst_addr_ack", ack, 0);
        write_byte(8'h30, ack);
        write_byte(8'h77, ack); check("post_rst_d_ack", ack, 0);
        i2c_stop;
        check("post_rst_we_addr", we_a[we_base % 64], 8'h30);
        check("post_rst_we_data", we_d[we_base % 64], 8'h77);

        // One-cycle SDA glitch with SCL high on an idle bus
        tick(Q);
        busy_base = busy_cnt;
        sda_m = 1'b0;
        tick(1);
        sda_m = 1'b1;
        tick(12);
`ifdef HIF_I2C_GLITCH_FILTER_EN
        check("glitch_busy_seen", busy_cnt != busy_base, 0);
`else
        check("glitch_busy_seen", busy_cnt != busy_base, 1);
`endif
        check("glitch_busy_end", busy, 0);
        check("glitch_idle_end", hif_idle_out, 1);

        check("no_we_re_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
